chip8_framebuffer: RTL and testbench
====================================

Name: chip8_framebuffer

Overview:
- 64x32 monochrome CHIP-8 display memory (2048 bits) with two independent ports.
- Port A: read-only pixel port for the VGA scan-out stage; it answers fb_request_addr with fb_pixel_data.
- Port B: owned by a drawing engine that executes CLS (clear) and DXYN (XOR sprite draw with collision detect) for the CPU. Sprite bytes are fetched from CHIP-8 main memory.
- The CPU issues a one-cycle command and waits for done.

Parameters:
- FB_W, 64, framebuffer width in pixels (power of 2).
- FB_H, 32, framebuffer height in pixels (power of 2).
- FB_AW, 11, framebuffer address width; address = y*FB_W + x.
- MEM_AW, 12, CHIP-8 main memory address width.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- fb_request_addr  in  FB_AW  pixel address from VGA stage.
- fb_pixel_data  out  1  registered pixel value for fb_request_addr.
- cmd_clear  in  1  one-cycle pulse: clear whole framebuffer.
- cmd_draw  in  1  one-cycle pulse: draw sprite.
- draw_x  in  8  VX value; column = draw_x mod FB_W.
- draw_y  in  8  VY value; row = draw_y mod FB_H.
- draw_n  in  4  sprite height N in rows.
- draw_i  in  MEM_AW  sprite base address (I register).
- mem_addr  out  MEM_AW  sprite byte address.
- mem_rd  out  1  read strobe to main memory.
- mem_rdata  in  8  sprite byte; valid the cycle after mem_rd.
- busy  out  1  engine not idle.
- done  out  1  one-cycle completion pulse.
- collision  out  1  VF result of the last draw.

Behaviour:
- Reset: async, active-high.
  - FSM goes to IDLE.
  - busy, done, collision, mem_rd, fb_pixel_data go to 0; mem_addr goes to 0.
  - Framebuffer contents are not reset. A reset mid-operation abandons the command and leaves partially written pixels as they are.
- Port A (read):
  - fb_pixel_data <= fb[fb_request_addr] on every clk50 edge; latency 1 cycle.
  - Port A is never stalled by port B.
  - Same-address collision with a port B write in the same cycle returns the old value (read-before-write).
- Command accept:
  - Commands are sampled only in IDLE and ignored while busy.
  - If cmd_clear and cmd_draw arrive together, cmd_clear wins and the draw is dropped.
  - draw_x, draw_y, draw_n and draw_i are latched on the accepting edge.
  - busy = (state != IDLE).
- FSM states: IDLE, CLEAR, FETCH, WAIT, PIX_RD, PIX_WR, DONE.
- IDLE:
  - cmd_clear goes to CLEAR with counter 0.
  - cmd_draw with N=0 goes directly to DONE and clears collision.
  - cmd_draw with N>0 goes to FETCH with row r=0 and clears collision.
- CLEAR: writes 0 at the counter address and increments; after address 2047 it goes to DONE. 2048 cycles total.
- FETCH: mem_rd=1, mem_addr=(I+r) mod 2^MEM_AW; goes to WAIT.
- WAIT: captures mem_rdata into the sprite shift register; column c=0; goes to PIX_RD.
- PIX_RD:
  - Target address = ((y+r) mod FB_H)*FB_W + ((x+c) mod FB_W).
  - Reads the old pixel; goes to PIX_WR.
- PIX_WR:
  - new = old XOR bit(7-c); written to the target address.
  - If old=1 and bit=1, collision <= 1.
  - If c<7: c++ and go to PIX_RD.
  - Else if r<N-1: r++ and go to FETCH.
  - Else go to DONE.
  - Zero bits still consume both cycles, so timing is fixed.
- DONE: done=1 for one cycle; goes to IDLE.
- Timing, measured from the accepting edge T:
  - done is high in cycle T+18N+1 for draw (N>0).
  - done is high in cycle T+2049 for clear.
  - done is high in cycle T+1 for N=0.
- collision holds its value until the next draw is accepted. CLS does not change it.

Optional Feature:
- Macro: CHIP8_FB_CLIP_EN.
- Defined:
  - The start coordinate still wraps (mod FB_W / FB_H).
  - Pixels where x0+c >= FB_W or y0+r >= FB_H are not written and cannot set collision.
  - Cycle timing is unchanged.
- Undefined: full wrap on both axes as described in Behaviour.

Test Plan:
- CLS, then read every address on port A → done exactly 2049 cycles after accept; all 2048 pixels read 0; fb_pixel_data is 1 cycle behind fb_request_addr.
- After CLS: draw x=0, y=0, N=1, I=0x050 with mem[0x050]=0xF0 → mem_addr=0x050 seen once; done at T+19; pixels 0..3=1, 4..7=0; collision=0.
- Repeat the identical draw → pixels 0..7 all 0; collision=1; a following CLS leaves collision=1.
- Wrap (macro off): x=62, y=31, N=1, byte 0xC3 → pixels 2046, 2047, 1988, 1989 set; no others. With CHIP8_FB_CLIP_EN: only 2046 and 2047 set.
- Draw x=70, y=40, N=2 → wraps to column 6, row 8 (address 518 onward); done at T+37. cmd_draw/cmd_clear pulsed while busy → ignored, no extra done. cmd_clear+cmd_draw together in IDLE → clear only.
- Assert reset during PIX_RD of row 1 → busy/done/collision go to 0 immediately; row-0 pixels remain written; next command is accepted normally.

Source files
------------

// File: rtl/chip8_framebuffer.sv
// chip8_framebuffer: 64x32 CHIP-8 display memory with a VGA read port and a CLS/DXYN drawing engine.
// Optional CHIP8_FB_CLIP_EN: sprites clip at the right/bottom edges instead of wrapping.
module chip8_framebuffer #(
    parameter int FB_W   = 64,
    parameter int FB_H   = 32,
    parameter int FB_AW  = 11,
    parameter int MEM_AW = 12
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic [FB_AW-1:0]  fb_request_addr,
    output logic              fb_pixel_data,
    input  logic              cmd_clear,
    input  logic              cmd_draw,
    input  logic [7:0]        draw_x,
    input  logic [7:0]        draw_y,
    input  logic [3:0]        draw_n,
    input  logic [MEM_AW-1:0] draw_i,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              collision
);
    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT, PIX_RD, PIX_WR, DONE} state_t;

    state_t            state;
    logic              fb [FB_W*FB_H];
    logic [FB_AW-1:0]  cnt, tgt, waddr;
    logic [XW-1:0]     x0;
    logic [YW-1:0]     y0;
    logic [3:0]        n, r;
    logic [2:0]        c;
    logic [MEM_AW-1:0] base;
    logic [7:0]        sprite;
    logic              old, bit_v, vis, we;

`ifdef CHIP8_FB_CLIP_EN
    logic [XW:0] xs;
    logic [YW:0] ys;
    assign xs  = {1'b0, x0} + (XW+1)'(c);
    assign ys  = {1'b0, y0} + (YW+1)'(r);
    assign tgt = {ys[YW-1:0], xs[XW-1:0]};
    assign vis = !xs[XW] && !ys[YW];
`else
    assign tgt = {y0 + YW'(r), x0 + XW'(c)};
    assign vis = 1'b1;
`endif

    assign bit_v = sprite[3'd7 - c];
    assign busy  = state != IDLE;
    assign we    = state == CLEAR || (state == PIX_WR && vis);
    assign waddr = state == CLEAR ? cnt : tgt;

    always_ff @(posedge clk50)
        if (we) fb[waddr] <= state == PIX_WR && (old ^ bit_v);

    // Port A runs every cycle regardless of the engine; NBA ordering gives read-before-write.
    always_ff @(posedge clk50 or posedge reset)
        if (reset) fb_pixel_data <= 1'b0;
        else       fb_pixel_data <= fb[fb_request_addr];

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            collision <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            cnt       <= '0;
            x0        <= '0;
            y0        <= '0;
            n         <= '0;
            r         <= '0;
            c         <= '0;
            base      <= '0;
            sprite    <= '0;
            old       <= 1'b0;
        end else begin
            done   <= 1'b0;
            mem_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_clear) begin
                        cnt   <= '0;
                        state <= CLEAR;
                    end else if (cmd_draw) begin
                        x0        <= XW'(draw_x % FB_W);
                        y0        <= YW'(draw_y % FB_H);
                        n         <= draw_n;
                        base      <= draw_i;
                        r         <= '0;
                        collision <= 1'b0;
                        mem_addr  <= draw_i;
                        mem_rd    <= draw_n != 4'd0;
                        done      <= draw_n == 4'd0;
                        state     <= draw_n == 4'd0 ? DONE : FETCH;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    sprite <= mem_rdata;
                    c      <= '0;
                    state  <= PIX_RD;
                end
                PIX_RD: begin
                    old   <= fb[tgt];
                    state <= PIX_WR;
                end
                PIX_WR: begin
                    if (vis && old && bit_v) collision <= 1'b1;
                    if (c != 3'd7) begin
                        c     <= c + 1'b1;
                        state <= PIX_RD;
                    end else if (r != n - 4'd1) begin
                        r        <= r + 1'b1;
                        mem_addr <= base + MEM_AW'(r) + 1'b1;
                        mem_rd   <= 1'b1;
                        state    <= FETCH;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chip8_framebuffer.sv
// tb_chip8_framebuffer: randomized CLS/DXYN commands checked against a pixel-array model of the display.
module tb_chip8_framebuffer;
    logic        clk50 = 1'b0;
    logic        reset;
    logic [10:0] fb_request_addr;
    logic        fb_pixel_data;
    logic        cmd_clear, cmd_draw;
    logic [7:0]  draw_x, draw_y;
    logic [3:0]  draw_n;
    logic [11:0] draw_i, mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        busy, done, collision;

    chip8_framebuffer dut (
        .clk50(clk50), .reset(reset), .fb_request_addr(fb_request_addr), .fb_pixel_data(fb_pixel_data),
        .cmd_clear(cmd_clear), .cmd_draw(cmd_draw), .draw_x(draw_x), .draw_y(draw_y), .draw_n(draw_n),
        .draw_i(draw_i), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .collision(collision)
    );

    always #5 clk50 = ~clk50;

    logic [7:0]  mem [4096];
    logic        model [2048];
    logic        coll_m;
    logic [11:0] fetched [$];
    int          vectors = 0, errs = 0;

    always @(posedge clk50) begin
        if (mem_rd && !reset) fetched.push_back(mem_addr);
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_draw(input logic [7:0] x, input logic [7:0] y, input int rows, input logic [11:0] i);
        coll_m = 1'b0;
        for (int rr = 0; rr < rows; rr++) begin
            logic [7:0] b;
            b = mem[(int'(i) + rr) % 4096];
            for (int cc = 0; cc < 8; cc++) begin
                int col, row, a;
                col = int'(x) % 64 + cc;
                row = int'(y) % 32 + rr;
`ifdef CHIP8_FB_CLIP_EN
                if (col >= 64 || row >= 32) continue;
`endif
                a = (row % 32) * 64 + col % 64;
                if (model[a] && b[7-cc]) coll_m = 1'b1;
                model[a] = model[a] ^ b[7-cc];
            end
        end
    endtask

    task automatic readback(input int lo, input int hi);
        for (int a = lo; a <= hi + 1; a++) begin
            @(negedge clk50);
            if (a > lo) check($sformatf("pix%0d", a - 1), fb_pixel_data, model[a-1]);
            if (a <= hi) fb_request_addr = 11'(a);
        end
    endtask

    task automatic issue(input logic clr, input logic drw, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] i, input int poke);
        int got, exp_lat, extra;
        @(negedge clk50);
        cmd_clear = clr; cmd_draw = drw; draw_x = x; draw_y = y; draw_n = n; draw_i = i;
        fetched.delete();
        @(posedge clk50);
        got = -1;
        for (int k = 1; k <= 3000 && got < 0; k++) begin
            if (k > 1) @(negedge clk50);
            else @(negedge clk50);
            cmd_clear = 1'b0; cmd_draw = 1'b0;
            draw_x = 8'($urandom); draw_y = 8'($urandom); draw_n = 4'($urandom); draw_i = 12'($urandom);
            if (k == 1) check("busy_after_accept", busy, 1);
            if (k == poke) begin cmd_clear = 1'b1; cmd_draw = 1'b1; end
            if (done) got = k;
        end
        exp_lat = clr ? 2049 : (n == 0 ? 1 : 18 * int'(n) + 1);
        check("done_latency", got, exp_lat);
        if (clr) foreach (model[a]) model[a] = 1'b0;
        else model_draw(x, y, int'(n), i);
        check("fetch_count", fetched.size(), clr ? 0 : int'(n));
        for (int j = 0; j < fetched.size() && j < 16; j++)
            check("fetch_addr", fetched[j], (int'(i) + j) % 4096);
        check("collision", collision, coll_m);
        if (poke > 0) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk50);
                if (done || busy) extra++;
            end
            check("no_extra_done", extra, 0);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_clear = 1'b0; cmd_draw = 1'b0;
        draw_x = '0; draw_y = '0; draw_n = '0; draw_i = '0; fb_request_addr = '0;
        coll_m = 1'b0;
        foreach (mem[a]) mem[a] = 8'($urandom);
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_coll", collision, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pix", fb_pixel_data, 0);
        repeat (2) @(negedge clk50);
        reset = 1'b0;

        issue(1, 0, 0, 0, 0, 0, 0);
        readback(0, 2047);

        mem[12'h050] = 8'hF0;
        issue(0, 1, 0, 0, 1, 12'h050, 0);
        readback(0, 15);
        issue(0, 1, 0, 0, 1, 12'h050, 0);
        readback(0, 15);
        check("coll_second_draw", collision, 1);
        issue(1, 0, 0, 0, 0, 0, 0);
        check("coll_after_cls", collision, 1);

        mem[12'h100] = 8'hC3;
        issue(0, 1, 62, 31, 1, 12'h100, 0);
        readback(1984, 2047);

        issue(0, 1, 70, 40, 2, 12'h200, 5);
        readback(512, 600);
        model_draw(0, 0, 0, 0);
        issue(1, 1, 3, 3, 4, 12'h010, 0);
        readback(0, 2047);

        issue(0, 1, 8'($urandom), 8'($urandom), 4, 12'hFFE, 0);
        issue(0, 1, 8'($urandom), 8'($urandom), 0, 12'($urandom), 0);
        repeat (12) issue(0, 1, 8'($urandom), 8'($urandom), 4'($urandom_range(1, 15)), 12'($urandom), 0);
        readback(0, 2047);

        issue(1, 0, 0, 0, 0, 0, 0);
        mem[12'h300] = 8'hFF;
        issue(0, 1, 10, 5, 1, 12'h300, 0);
        @(negedge clk50);
        cmd_draw = 1'b1; draw_x = 10; draw_y = 5; draw_n = 3; draw_i = 12'h300;
        @(posedge clk50);
        @(negedge clk50);
        cmd_draw = 1'b0;
        repeat (19) @(negedge clk50);
        check("coll_pre_reset", collision, 1);
        @(negedge clk50);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_coll", collision, 0);
        check("midrst_mem_rd", mem_rd, 0);
        model_draw(10, 5, 1, 12'h300);
        coll_m = 1'b0;
        @(negedge clk50);
        reset = 1'b0;
        readback(0, 2047);
        issue(0, 1, 8'($urandom), 8'($urandom), 3, 12'($urandom), 0);
        readback(0, 2047);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
